// File: rtl/psum_accum_ctrl_if.sv
// psum_accum_ctrl_if: OFIFO pop port and PMEM (OP SRAM) port bundled for the psum accumulator
// Signals:
//   ofifo_valid/ofifo_out/ofifo_rd : first-word-fall-through OFIFO head and pop strobe
//   OP_q/OP_d/OP_addr/OP_cen/OP_wen: PMEM read data, write data, address, active-low enables
// master = accumulator controller, slave = OFIFO + PMEM side.
interface psum_accum_ctrl_if #(parameter int col = 8, parameter int psum_bw = 16);
    logic                     ofifo_valid;
    logic [col*psum_bw-1:0]   ofifo_out;
    logic                     ofifo_rd;
    logic [col*psum_bw-1:0]   OP_q;
    logic [col*psum_bw-1:0]   OP_d;
    logic [8:0]               OP_addr;
    logic                     OP_cen;
    logic                     OP_wen;
    modport master (input ofifo_valid, ofifo_out, OP_q, output ofifo_rd, OP_d, OP_addr, OP_cen, OP_wen);
    modport slave (output ofifo_valid, ofifo_out, OP_q, input ofifo_rd, OP_d, OP_addr, OP_cen, OP_wen);
endinterface

// File: rtl/psum_accum_ctrl.sv
// psum_accum_ctrl: read-modify-write accumulation of OFIFO psum vectors into PMEM for one kij pass
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   start                       : one-cycle pulse, accepted only in IDLE
//   first_pass, relu_en         : sampled with start (overwrite PMEM / clamp negatives)
//   base_addr                   : PMEM address of vector 0 (addresses wrap modulo 512)
//   bus                         : OFIFO pop port and PMEM port (master side)
//   busy, done, sat_flag        : not-IDLE, pass-complete pulse, sticky lane saturation
module psum_accum_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int num_out = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       first_pass,
    input  logic       relu_en,
    input  logic [8:0] base_addr,
    psum_accum_ctrl_if.master bus,
    output logic       busy,
    output logic       done,
    output logic       sat_flag
);
    localparam int w = col * psum_bw;
    typedef enum logic [1:0] {IDLE, FETCH, ACC, DONE} state_t;
    state_t state, state_n;
    logic [8:0] index, base_q, addr;
    logic fp_q, relu_q, last;
    logic [w-1:0] vec_q, result;
    logic [col-1:0] sat;

    assign addr = base_q + index;
    assign last = index == 9'(num_out - 1);
    assign busy = state != IDLE;
    assign done = state == DONE;

    genvar i;
    generate
        for (i = 0; i < col; i++) begin : g_lane
            logic [psum_bw-1:0] old, inc, clip;
            logic [psum_bw:0] sum;
            assign old = fp_q ? '0 : bus.OP_q[i*psum_bw +: psum_bw];
            assign inc = vec_q[i*psum_bw +: psum_bw];
            assign sum = {old[psum_bw-1], old} + {inc[psum_bw-1], inc};
            // The two top bits of the sign-extended sum differ exactly on overflow;
            // the top bit then gives the direction to clamp toward.
            assign sat[i] = sum[psum_bw] ^ sum[psum_bw-1];
            assign clip = sat[i] ? {sum[psum_bw], {(psum_bw-1){~sum[psum_bw]}}} : sum[psum_bw-1:0];
            assign result[i*psum_bw +: psum_bw] = (relu_q && clip[psum_bw-1]) ? '0 : clip;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            index    <= '0;
            base_q   <= '0;
            fp_q     <= 1'b0;
            relu_q   <= 1'b0;
            vec_q    <= '0;
            sat_flag <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                fp_q     <= first_pass;
                relu_q   <= relu_en;
                base_q   <= base_addr;
                index    <= '0;
                sat_flag <= 1'b0;
            end
            if (state == FETCH && bus.ofifo_valid) vec_q <= bus.ofifo_out;
            if (state == ACC) begin
                sat_flag <= sat_flag | (|sat);
                if (!last) index <= index + 9'd1;
            end
        end
    end

    always_comb begin
        state_n     = state;
        bus.ofifo_rd = 1'b0;
        bus.OP_cen  = 1'b1;
        bus.OP_wen  = 1'b1;
        bus.OP_addr = '0;
        bus.OP_d    = '0;
        case (state)
            IDLE:  state_n = start ? FETCH : IDLE;
            FETCH: if (bus.ofifo_valid) begin
                bus.ofifo_rd = 1'b1;
                bus.OP_cen  = fp_q;
                bus.OP_addr = addr;
                state_n     = ACC;
            end
            ACC: begin
                bus.OP_cen  = 1'b0;
                bus.OP_wen  = 1'b0;
                bus.OP_addr = addr;
                bus.OP_d    = result;
                state_n     = last ? DONE : FETCH;
            end
            DONE:  state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_psum_accum_ctrl.sv
// tb_psum_accum_ctrl: directed bench for psum_accum_ctrl with a behavioural PMEM and a held OFIFO head
// Ports: none (top-level bench); DUT runs with num_out=4.
module tb_psum_accum_ctrl;
    logic clk, reset, start, first_pass, relu_en, busy, done, sat_flag;
    logic [8:0] base_addr;
    psum_accum_ctrl_if bus ();

    psum_accum_ctrl #(.col(8), .psum_bw(16), .num_out(4)) dut (
        .clk(clk), .reset(reset), .start(start), .first_pass(first_pass), .relu_en(relu_en),
        .base_addr(base_addr), .bus(bus), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] mem [0:511];
    logic [8:0] wr_log [0:63];
    logic prev_rd;
    logic [8:0] prev_addr;
    int pops, bad_pops, reads, writes, no_rmw;
    int n_checks, n_fail;

    always @(posedge clk) begin
        if (bus.ofifo_rd) pops <= pops + 1;
        if (bus.ofifo_rd && !bus.ofifo_valid) bad_pops <= bad_pops + 1;
        if (!bus.OP_cen && bus.OP_wen) begin
            reads    <= reads + 1;
            bus.OP_q <= mem[bus.OP_addr];
        end
        if (!bus.OP_cen && !bus.OP_wen) begin
            writes <= writes + 1;
            mem[bus.OP_addr] <= bus.OP_d;
            wr_log[writes[5:0]] <= bus.OP_addr;
            if (!(prev_rd && prev_addr == bus.OP_addr)) no_rmw <= no_rmw + 1;
        end
        prev_rd   <= !bus.OP_cen && bus.OP_wen;
        prev_addr <= bus.OP_addr;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag, input logic [8:0] base, input logic [127:0] exp);
        for (int k = 0; k < 4; k++) check(tag, mem[9'(base + 9'(k))], exp);
    endtask

    // Runs one pass; optional stall of ofifo_valid after stall_at pops, a start poke while busy,
    // or a reset after rst_at pops. cyc counts cycles from FETCH entry through DONE.
    task automatic run_pass(input logic fp, input logic relu, input logic [8:0] base, input logic [127:0] vec,
                            input int stall_at, input bit poke, input int rst_at, output int cyc);
        int p0;
        bit stalled;
        p0 = pops;
        stalled = 0;
        @(negedge clk);
        ofifo_drive(vec);
        first_pass = fp;
        relu_en = relu;
        base_addr = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            start = poke && cyc == 3;
            if (poke && cyc == 3) begin
                first_pass = 1'b0;
                base_addr = 9'd100;
            end
            if (rst_at >= 0 && pops - p0 == rst_at) begin
                reset = 1'b1;
                #1;
                check("rst_mid_busy", busy, 0);
                check("rst_mid_cen", bus.OP_cen, 1);
                check("rst_mid_rd", bus.ofifo_rd, 0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (stall_at >= 0 && !stalled && pops - p0 == stall_at) begin
                stalled = 1;
                bus.ofifo_valid = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    cyc++;
                    check("stall_rd", bus.ofifo_rd, 0);
                    check("stall_cen", bus.OP_cen, 1);
                end
                bus.ofifo_valid = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic ofifo_drive(input logic [127:0] vec);
        bus.ofifo_out = vec;
        bus.ofifo_valid = 1'b1;
    endtask

    localparam logic [127:0] S0 = {{6{16'h0064}}, 16'h8000, 16'h7d00};
    localparam logic [127:0] S1 = {{6{16'hffce}}, 16'hffff, 16'h03e8};
    localparam logic [127:0] SR = {{6{16'h0032}}, 16'h8000, 16'h7fff};

    initial begin
        int cyc, r0, w0, p0, n0;
        reset = 1'b1;
        start = 1'b0;
        first_pass = 1'b0;
        relu_en = 1'b0;
        base_addr = '0;
        bus.ofifo_valid = 1'b0;
        bus.ofifo_out = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_rd", bus.ofifo_rd, 0);
        check("rst_cen", bus.OP_cen, 1);
        check("rst_wen", bus.OP_wen, 1);
        check("rst_addr", bus.OP_addr, 0);
        check("rst_d", bus.OP_d, 0);
        reset = 1'b0;

        r0 = reads; w0 = writes; p0 = pops;
        run_pass(1, 0, 9'd0, {8{16'd5}}, -1, 0, -1, cyc);
        check("fp_cycles", cyc, 9);
        check("fp_reads", reads - r0, 0);
        check("fp_writes", writes - w0, 4);
        check("fp_pops", pops - p0, 4);
        check("fp_sat", sat_flag, 0);
        check_mem("fp_mem", 9'd0, {8{16'd5}});

        r0 = reads; n0 = no_rmw;
        run_pass(0, 0, 9'd0, {8{16'hfff9}}, -1, 0, -1, cyc);
        check("acc_cycles", cyc, 9);
        check("acc_reads", reads - r0, 4);
        check("acc_rmw", no_rmw - n0, 0);
        check_mem("acc_mem", 9'd0, {8{16'hfffe}});

        r0 = reads;
        run_pass(0, 1, 9'd0, {8{16'hfff9}}, -1, 0, -1, cyc);
        check("relu_reads", reads - r0, 4);
        check_mem("relu_mem", 9'd0, '0);

        run_pass(1, 0, 9'd20, S0, -1, 0, -1, cyc);
        check("sat_pre_flag", sat_flag, 0);
        run_pass(0, 0, 9'd20, S1, -1, 0, -1, cyc);
        check("sat_flag", sat_flag, 1);
        check_mem("sat_mem", 9'd20, SR);

        p0 = pops; n0 = no_rmw;
        run_pass(0, 0, 9'd0, {8{16'd3}}, 2, 0, -1, cyc);
        check("stall_cycles", cyc, 13);
        check("stall_pops", pops - p0, 4);
        check("stall_rmw", no_rmw - n0, 0);
        check("stall_sat_clr", sat_flag, 0);
        check_mem("stall_mem", 9'd0, {8{16'd3}});

        r0 = reads; w0 = writes;
        run_pass(1, 0, 9'd510, {8{16'd9}}, -1, 1, -1, cyc);
        check("wrap_reads", reads - r0, 0);
        check("wrap_writes", writes - w0, 4);
        check("wrap_a0", wr_log[(w0 + 0) % 64], 510);
        check("wrap_a1", wr_log[(w0 + 1) % 64], 511);
        check("wrap_a2", wr_log[(w0 + 2) % 64], 0);
        check("wrap_a3", wr_log[(w0 + 3) % 64], 1);
        check("wrap_m510", mem[510], {8{16'd9}});
        check("wrap_m1", mem[1], {8{16'd9}});

        run_pass(1, 0, 9'd40, {8{16'd11}}, -1, 0, 2, cyc);
        w0 = writes;
        run_pass(1, 0, 9'd40, {8{16'd12}}, -1, 0, -1, cyc);
        check("restart_cycles", cyc, 9);
        check("restart_writes", writes - w0, 4);
        check_mem("restart_mem", 9'd40, {8{16'd12}});
        check("bad_pops", bad_pops, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/psum_accum_ctrl.md
Name: psum_accum_ctrl

Overview:
- Sequences read-modify-write accumulation of partial sums from the OFIFO into PMEM (the 128-bit OP SRAM) for one kernel position (kij) pass.
- For each output vector, it pops one 8-lane psum vector from the OFIFO and reads the matching PMEM word. It then adds the two lane by lane with saturation and writes the result back to the same address.
- It sits between the OFIFO and the OP SRAM port. The corelet top FSM starts it once per kij pass and waits for `done`.

Parameters:
- col, 8, number of psum lanes per vector
- psum_bw, 16, signed width of each lane
- num_out, 16, output vectors accumulated per pass (1..512)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a pass (sampled only in IDLE)
- first_pass  in  1  sampled with start; 1 = overwrite PMEM without reading it
- relu_en  in  1  sampled with start; 1 = clamp negative results to 0 before write
- base_addr  in  9  PMEM address of vector 0 of this pass
- ofifo_valid  in  1  OFIFO holds a vector (first-word-fall-through)
- ofifo_out  in  col*psum_bw  OFIFO head vector; lane i = bits [16i+15:16i]
- ofifo_rd  out  1  pop strobe; the head is consumed in any cycle with ofifo_rd=1
- OP_q  in  col*psum_bw  PMEM read data, valid the cycle after a read
- OP_d  out  col*psum_bw  PMEM write data
- OP_addr  out  9  PMEM address
- OP_cen  out  1  PMEM chip enable, active low
- OP_wen  out  1  PMEM write enable, active low (0 = write)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the pass completes
- sat_flag  out  1  sticky: some lane saturated this pass; cleared at start

Behaviour:
- Reset values (asynchronous): state=IDLE, index=0, ofifo_rd=0, OP_cen=1, OP_wen=1, OP_addr=0, OP_d=0, busy=0, done=0, sat_flag=0. Latched first_pass, relu_en, base_addr and the latched vector all reset to 0.
- Outputs are decoded combinationally from registered state and registers.
- States: IDLE, FETCH, ACC, DONE.
- IDLE
  - On start=1: latch first_pass, relu_en and base_addr; set index=0; clear sat_flag; go to FETCH.
  - start=0: stay in IDLE.
- FETCH
  - ofifo_valid=0: drive no strobes; stay in FETCH. Stalls are unbounded.
  - ofifo_valid=1: assert ofifo_rd=1 and latch ofifo_out.
  - If latched first_pass=0, also drive OP_cen=0, OP_wen=1, OP_addr=base+index (a read).
  - Go to ACC.
- ACC
  - old = OP_q if first_pass=0, else 0.
  - Per lane: sum = old + vec as signed, computed at psum_bw+1 bits.
  - Saturation: above +32767 gives 32767; below -32768 gives -32768. Any saturated lane sets sat_flag.
  - If relu_en=1, a negative sum becomes 0 (applied after saturation).
  - Drive OP_cen=0, OP_wen=0, OP_addr=base+index, OP_d=result.
  - If index==num_out-1, go to DONE; else index+1 and go to FETCH.
- DONE: done=1 for one cycle, busy=1; next state is IDLE.
- Address arithmetic is modulo 512: base_addr=510 with num_out=4 uses addresses 510, 511, 0, 1.
- Throughput is 2 cycles per vector with no stalls. Latency from the start cycle to the first FETCH is 1 cycle.
- A pass with no stalls takes 2*num_out+1 cycles from FETCH entry through DONE.
- start while busy=1 is ignored and has no effect on the latched fields.
- start in the DONE cycle is ignored; start is accepted again from the following IDLE cycle.
- ofifo_rd is never asserted while ofifo_valid=0. At most one pop occurs per vector.
- Reads and writes never occur in the same cycle. The read issued in FETCH is always consumed in the immediately following ACC.
- Reset mid-pass returns to IDLE at once with all strobes deasserted. A write in flight when reset asserts is not guaranteed. Vectors already popped are lost; the top FSM restarts the pass.

Test Plan:
- first_pass=1, base=0, num_out=4, OFIFO lanes all 5, ofifo_valid held 1 -> PMEM[0..3] lanes = 5. No OP reads occur. done pulses 9 cycles after the first FETCH. sat_flag=0.
- Second pass with first_pass=0 and the same base, OFIFO lanes = -7 -> every lane = -2. Each write is preceded by a read of the same address one cycle earlier.
- Same as the previous scenario but relu_en=1 -> every lane written as 0.
- PMEM lane holds 32000 and OFIFO lane holds 1000 -> write 32767 and sat_flag=1. A lane holding -32768 plus -1 -> write -32768.
- Deassert ofifo_valid for 5 cycles mid-pass -> FSM holds in FETCH with OP_cen=1 and ofifo_rd=0. The pass completes correctly with exactly num_out pops.
- base=510, num_out=4 -> writes at 510, 511, 0, 1. A start pulse while busy is ignored. Reset asserted after 2 vectors -> busy=0 and OP_cen=1 immediately, and a new start runs a clean pass.
